lcd_controller: RTL and testbench

LCD_CONTROLLER -- requirements
Module: lcd_controller

---
 rtl/lcd_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_lcd_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
// HD44780 character-LCD driver: runs the panel init sequence, then draws one instruction/result line.
// Define LCD_BINARY_LINE_EN to also draw lcd_value in binary on line 2.
module lcd_controller #(
    parameter int unsigned INIT_WAIT_CYC  = 750000,
    parameter int unsigned EN_PULSE_CYC   = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_update,
    input  logic [2:0]  lcd_opcode,
    input  logic [3:0]  lcd_reg_idx,
    input  logic [15:0] lcd_value,
    output logic        lcd_busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        lcd_blon
);

    typedef enum logic [2:0] {StInitWait, StInitCmd, StIdle, StConvert, StWrite} state_e;
    typedef enum logic [1:0] {PhSetup, PhPulse, PhWait} phase_e;

`ifdef LCD_BINARY_LINE_EN
    localparam logic [5:0] LAST_IDX = 6'd33;
`else
    localparam logic [5:0] LAST_IDX = 6'd16;
`endif

    state_e      state_q;
    phase_e      phase_q;
    logic [31:0] cnt_q;
    logic [5:0]  idx_q;
    logic [2:0]  op_q;
    logic [3:0]  reg_q;
    logic [15:0] val_q;
    logic [15:0] bin_q;
    logic [19:0] bcd_q;

    logic [5:0]  nidx;
    logic [3:0]  pos;
    logic [39:0] mnem;
    logic [7:0]  line_char;
    logic [7:0]  frame_nxt;
    logic        frame_nxt_rs;
    logic [7:0]  init_nxt;
    logic [31:0] wait_len;
    logic [15:0] mag;
    logic [19:0] bcd_adj;
    logic [35:0] dd_shift;
    logic [3:0]  ones;

    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

    always_comb begin
        nidx = idx_q + 6'd1;
        pos  = nidx[3:0] - 4'd1;
        ones = (reg_q >= 4'd10) ? reg_q - 4'd10 : reg_q;

        case (op_q)
            3'd0:    mnem = "LOAD ";
            3'd1:    mnem = "ADD  ";
            3'd2:    mnem = "ADDI ";
            3'd3:    mnem = "SUB  ";
            3'd4:    mnem = "SUBI ";
            3'd5:    mnem = "MUL  ";
            3'd6:    mnem = "CLEAR";
            default: mnem = "DPL  ";
        endcase

        case (pos)
            4'd0:    line_char = mnem[39:32];
            4'd1:    line_char = mnem[31:24];
            4'd2:    line_char = mnem[23:16];
            4'd3:    line_char = mnem[15:8];
            4'd4:    line_char = mnem[7:0];
            4'd6:    line_char = "R";
            4'd7:    line_char = (reg_q >= 4'd10) ? "1" : "0";
            4'd8:    line_char = {4'h3, ones};
            4'd10:   line_char = val_q[15] ? "-" : "+";
            4'd11:   line_char = {4'h3, bcd_q[19:16]};
            4'd12:   line_char = {4'h3, bcd_q[15:12]};
            4'd13:   line_char = {4'h3, bcd_q[11:8]};
            4'd14:   line_char = {4'h3, bcd_q[7:4]};
            4'd15:   line_char = {4'h3, bcd_q[3:0]};
            default: line_char = " ";
        endcase

        frame_nxt    = line_char;
        frame_nxt_rs = 1'b1;
`ifdef LCD_BINARY_LINE_EN
        if (nidx == 6'd17) begin
            frame_nxt    = 8'hC0;
            frame_nxt_rs = 1'b0;
        end else if (nidx >= 6'd18) begin
            frame_nxt = val_q[4'(6'd33 - nidx)] ? "1" : "0";
        end
`endif

        case (idx_q[1:0])
            2'd0:    init_nxt = 8'h0C;
            2'd1:    init_nxt = 8'h01;
            default: init_nxt = 8'h06;
        endcase

        wait_len = (!lcd_rs && lcd_data == 8'h01) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;

        // Two's-complement magnitude; 0x8000 maps to 32768 as unsigned.
        mag = lcd_value[15] ? (~lcd_value + 16'd1) : lcd_value;

        // Double-dabble: add 3 to any BCD digit >= 5, then shift one binary bit in.
        for (int i = 0; i < 5; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                            : bcd_q[4*i +: 4];
        end
        dd_shift = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StInitWait;
            phase_q  <= PhSetup;
            cnt_q    <= '0;
            idx_q    <= '0;
            op_q     <= '0;
            reg_q    <= '0;
            val_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            lcd_busy <= 1'b1;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (state_q)
                StInitWait: begin
                    if (cnt_q == INIT_WAIT_CYC - 32'd1) begin
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        phase_q  <= PhSetup;
                        lcd_rs   <= 1'b0;
                        lcd_data <= 8'h38;
                        state_q  <= StInitCmd;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                StIdle: begin
                    if (lcd_update) begin
                        op_q     <= lcd_opcode;
                        reg_q    <= lcd_reg_idx;
                        val_q    <= lcd_value;
                        bin_q    <= mag;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        lcd_busy <= 1'b1;
                        state_q  <= StConvert;
                    end
                end

                StConvert: begin
                    bcd_q <= dd_shift[35:16];
                    bin_q <= dd_shift[15:0];
                    if (cnt_q == 32'd15) begin
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        phase_q  <= PhSetup;
                        lcd_rs   <= 1'b0;
                        lcd_data <= 8'h80;
                        state_q  <= StWrite;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                default: begin
                    // Shared transfer engine for StInitCmd and StWrite.
                    case (phase_q)
                        PhSetup: begin
                            lcd_en  <= 1'b1;
                            cnt_q   <= '0;
                            phase_q <= PhPulse;
                        end
                        PhPulse: begin
                            if (cnt_q == EN_PULSE_CYC - 32'd1) begin
                                lcd_en  <= 1'b0;
                                cnt_q   <= '0;
                                phase_q <= PhWait;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        default: begin
                            if (cnt_q == wait_len - 32'd1) begin
                                cnt_q <= '0;
                                if (idx_q == ((state_q == StInitCmd) ? 6'd3 : LAST_IDX)) begin
                                    lcd_busy <= 1'b0;
                                    state_q  <= StIdle;
                                end else begin
                                    idx_q   <= nidx;
                                    phase_q <= PhSetup;
                                    if (state_q == StInitCmd) begin
                                        lcd_rs   <= 1'b0;
                                        lcd_data <= init_nxt;
                                    end else begin
                                        lcd_rs   <= frame_nxt_rs;
                                        lcd_data <= frame_nxt;
                                    end
                                end
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller: init sequence, frame contents/timing, ignore rules, reset.
module tb_lcd_controller;

    localparam int INIT_W = 10;
    localparam int EN_W   = 2;
    localparam int CMD_W  = 3;
    localparam int CLR_W  = 6;
    localparam int LIMIT  = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_update;
    logic [2:0]  lcd_opcode;
    logic [3:0]  lcd_reg_idx;
    logic [15:0] lcd_value;
    logic        lcd_busy;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic        lcd_blon;

    int n_assert = 0;
    int n_fail   = 0;

    lcd_controller #(
        .INIT_WAIT_CYC (INIT_W),
        .EN_PULSE_CYC  (EN_W),
        .CMD_WAIT_CYC  (CMD_W),
        .CLEAR_WAIT_CYC(CLR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_update (lcd_update),
        .lcd_opcode (lcd_opcode),
        .lcd_reg_idx(lcd_reg_idx),
        .lcd_value  (lcd_value),
        .lcd_busy   (lcd_busy),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_on     (lcd_on),
        .lcd_blon   (lcd_blon)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with lcd_en low; returns {rs,data} one cycle before and at the rising edge.
    task automatic get_xfer(output logic [8:0] pre, output logic [8:0] at,
                            output int lo, output int hi);
        lo  = 0;
        hi  = 0;
        pre = {lcd_rs, lcd_data};
        while (!lcd_en && lo < LIMIT) begin
            pre = {lcd_rs, lcd_data};
            @(negedge clk);
            lo++;
        end
        at = {lcd_rs, lcd_data};
        while (lcd_en && hi < LIMIT) begin
            @(negedge clk);
            hi++;
        end
    endtask

    // lo_exp == 0 means the gap includes a conversion and only its bound is checked.
    task automatic xfer_chk(input string tag, input logic r_exp, input logic [7:0] d_exp,
                            input int lo_exp);
        logic [8:0] pre, at;
        int lo, hi;
        get_xfer(pre, at, lo, hi);
        chk({tag, ".byte"}, {14'd0, pre, at}, {14'd0, r_exp, d_exp, r_exp, d_exp});
        if (lo_exp == 0) chk({tag, ".latency_ok"}, 32'(lo >= 2 && lo <= 25), 32'd1);
        else             chk({tag, ".low"}, lo, lo_exp);
        chk({tag, ".high"}, hi, EN_W);
    endtask

    task automatic do_init(input string tag);
        xfer_chk({tag, ".i38"}, 1'b0, 8'h38, INIT_W + 1);
        xfer_chk({tag, ".i0C"}, 1'b0, 8'h0C, CMD_W + 1);
        xfer_chk({tag, ".i01"}, 1'b0, 8'h01, CMD_W + 1);
        xfer_chk({tag, ".i06"}, 1'b0, 8'h06, CLR_W + 1);
        chk({tag, ".busy_hold"}, lcd_busy, 1'b1);
        repeat (CMD_W) @(negedge clk);
        chk({tag, ".busy_fall"}, lcd_busy, 1'b0);
    endtask

    task automatic start_frame(input logic [2:0] op, input logic [3:0] ri, input logic [15:0] v);
        @(negedge clk);
        lcd_opcode  = op;
        lcd_reg_idx = ri;
        lcd_value   = v;
        lcd_update  = 1'b1;
        @(negedge clk);
        lcd_update  = 1'b0;
        chk("busy_after_accept", lcd_busy, 1'b1);
    endtask

    task automatic check_frame(input string tag, input string l1, input string l2, input int inject);
        int highs;
        bit busy_seen;
        xfer_chk({tag, ".cmd80"}, 1'b0, 8'h80, 0);
        for (int k = 0; k < 16; k++) begin
            xfer_chk($sformatf("%s.l1[%0d]", tag, k), 1'b1, l1[k], CMD_W + 1);
            if (k == inject) begin
                fork
                    begin
                        lcd_opcode  = 3'b101;
                        lcd_reg_idx = 4'd9;
                        lcd_value   = 16'h7FFF;
                        lcd_update  = 1'b1;
                        @(negedge clk);
                        lcd_update  = 1'b0;
                    end
                join_none
            end
        end
`ifdef LCD_BINARY_LINE_EN
        xfer_chk({tag, ".cmdC0"}, 1'b0, 8'hC0, CMD_W + 1);
        for (int k = 0; k < 16; k++) begin
            xfer_chk($sformatf("%s.l2[%0d]", tag, k), 1'b1, l2[k], CMD_W + 1);
        end
`endif
        chk({tag, ".busy_hold"}, lcd_busy, 1'b1);
        repeat (CMD_W) @(negedge clk);
        chk({tag, ".busy_fall"}, lcd_busy, 1'b0);
        // No further transfer may follow: frame length is exact and stray requests were dropped.
        highs = 0;
        busy_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (lcd_en) highs++;
            if (lcd_busy) busy_seen = 1'b1;
        end
        chk({tag, ".no_extra_xfer"}, highs, 0);
        chk({tag, ".stays_idle"}, 32'(busy_seen), 32'd0);
    endtask

    initial begin
        int w;
        rst         = 1'b1;
        lcd_update  = 1'b0;
        lcd_opcode  = 3'd0;
        lcd_reg_idx = 4'd0;
        lcd_value   = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {lcd_busy, lcd_en, lcd_rs, lcd_data, lcd_rw, lcd_on, lcd_blon},
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
        rst = 1'b0;
        do_init("init");

        start_frame(3'b001, 4'd3, 16'd42);
        check_frame("add", "ADD   R03 +00042", "0000000000101010", 5);

        start_frame(3'b111, 4'd15, 16'h8000);
        check_frame("dpl", "DPL   R15 -32768", "1000000000000000", -1);

        start_frame(3'b000, 4'd10, 16'd0);
        check_frame("load", "LOAD  R10 +00000", "0000000000000000", -1);

        start_frame(3'b110, 4'd0, 16'hFFFF);
        check_frame("clear", "CLEAR R00 -00001", "1111111111111111", -1);

        // Reset in the middle of an lcd_en pulse.
        start_frame(3'b010, 4'd7, 16'd1234);
        w = 0;
        while (!lcd_en && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid.en_reached", lcd_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid.async", {lcd_en, lcd_busy, lcd_rs, lcd_data}, {1'b0, 1'b1, 1'b0, 8'h00});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_init("reinit");

        start_frame(3'b100, 4'd12, 16'd99);
        check_frame("subi", "SUBI  R12 +00099", "0000000001100011", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
